// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up/down counter with wrap or stop-at-boundary
// behaviour, synchronous clear, terminal-count, wrap pulse and sticky done flag.
// Optional feature macro: MODCNT_LOAD_EN adds the LOAD/D parallel-load port pair
// (a load value at or above MODULUS is clamped to MODULUS-1).
module mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             MODE,
    input  logic             CLR,
`ifdef MODCNT_LOAD_EN
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic             at_bound;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             done_nxt;

`ifdef MODCNT_LOAD_EN
    // One extra bit so MODULUS = 2**WIDTH is representable in the clamp compare
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] load_val;

    // Clamp out-of-range load values to the top of the count range
    always_comb begin
        load_val = ({1'b0, D} < MOD_EXT) ? D : MAX_Q;
    end
`endif

    // Boundary for the current direction and the zero-latency terminal count
    always_comb begin
        at_bound = UP ? (Q == MAX_Q) : (Q == '0);
        TC       = EN & at_bound;
    end

    // Next-state: clear beats load beats count; otherwise hold
    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        done_nxt = DONE;
        if (CLR) begin
            q_nxt    = '0;
            done_nxt = 1'b0;
        end
`ifdef MODCNT_LOAD_EN
        else if (LOAD) begin
            q_nxt    = load_val;
            done_nxt = 1'b0;
        end
`endif
        else if (EN) begin
            if (!at_bound) begin
                q_nxt    = UP ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
                done_nxt = 1'b0;
            end else if (!MODE) begin
                q_nxt    = UP ? '0 : MAX_Q;
                wrap_nxt = 1'b1;
                done_nxt = 1'b0;
            end else begin
                done_nxt = 1'b1;
            end
        end
    end

    // Count, wrap-pulse and done registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q    <= '0;
            WRAP <= 1'b0;
            DONE <= 1'b0;
        end else begin
            Q    <= q_nxt;
            WRAP <= wrap_nxt;
            DONE <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: table-driven bench for mod_counter with a scoreboard queue,
// plus hand-written reset and WIDTH=4/MODULUS=16 sequences.
// Load vectors are included only when MODCNT_LOAD_EN is defined.
module tb_mod_counter;

    typedef struct {
        logic       en, up, mode, clr, load;
        logic [2:0] d;
        logic       tc;
        logic [2:0] q;
        logic       wrap, done;
    } vec_t;

    typedef struct {
        logic [2:0] q;
        logic       wrap, done;
    } res_t;

    logic       CLK;
    logic       RESET, EN, UP, MODE, CLR, LOAD;
    logic [2:0] D;
    logic [2:0] Q;
    logic       TC, WRAP, DONE;

    logic       rst16, en16, up16, mode16, clr16, load16;
    logic [3:0] d16;
    logic [3:0] q16;
    logic       tc16, wrap16, done16;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    vec_t vecs[$];
    res_t sb[$];

    mod_counter #(.WIDTH(3), .MODULUS(5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .UP    (UP),
        .MODE  (MODE),
        .CLR   (CLR),
`ifdef MODCNT_LOAD_EN
        .LOAD  (LOAD),
        .D     (D),
`endif
        .Q     (Q),
        .TC    (TC),
        .WRAP  (WRAP),
        .DONE  (DONE)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .CLK   (CLK),
        .RESET (rst16),
        .EN    (en16),
        .UP    (up16),
        .MODE  (mode16),
        .CLR   (clr16),
`ifdef MODCNT_LOAD_EN
        .LOAD  (load16),
        .D     (d16),
`endif
        .Q     (q16),
        .TC    (tc16),
        .WRAP  (wrap16),
        .DONE  (done16)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, up, mode, clr, load, input logic [2:0] d,
                                input logic tc, input logic [2:0] q, input logic wrap, done);
        vec_t v;
        v.en = en; v.up = up; v.mode = mode; v.clr = clr; v.load = load; v.d = d;
        v.tc = tc; v.q = q; v.wrap = wrap; v.done = done;
        vecs.push_back(v);
    endfunction

    initial begin
        res_t r;
        // columns: en up mode clr load d | tc(before edge) q wrap done (after edge)
        // count up with wrap, 12 edges
        add(1,1,0,0,0,0, 0,1,0,0); add(1,1,0,0,0,0, 0,2,0,0);
        add(1,1,0,0,0,0, 0,3,0,0); add(1,1,0,0,0,0, 0,4,0,0);
        add(1,1,0,0,0,0, 1,0,1,0); add(1,1,0,0,0,0, 0,1,0,0);
        add(1,1,0,0,0,0, 0,2,0,0); add(1,1,0,0,0,0, 0,3,0,0);
        add(1,1,0,0,0,0, 0,4,0,0); add(1,1,0,0,0,0, 1,0,1,0);
        add(1,1,0,0,0,0, 0,1,0,0); add(1,1,0,0,0,0, 0,2,0,0);
        // clear overrides enable
        add(1,1,0,1,0,0, 0,0,0,0);
        // count down with wrap from 0
        add(1,0,0,0,0,0, 1,4,1,0); add(1,0,0,0,0,0, 0,3,0,0);
        add(1,0,0,0,0,0, 0,2,0,0); add(1,0,0,0,0,0, 0,1,0,0);
        add(1,0,0,0,0,0, 0,0,0,0);
        // enable low at the boundary: no TC, hold
        add(0,0,0,0,0,0, 0,0,0,0);
        // up to 3, then stop mode
        add(1,1,0,0,0,0, 0,1,0,0); add(1,1,0,0,0,0, 0,2,0,0);
        add(1,1,0,0,0,0, 0,3,0,0);
        add(1,1,1,0,0,0, 0,4,0,0);
        add(1,1,1,0,0,0, 1,4,0,1);
        add(1,1,1,0,0,0, 1,4,0,1); add(1,1,1,0,0,0, 1,4,0,1);
        add(1,1,1,0,0,0, 1,4,0,1); add(1,1,1,0,0,0, 1,4,0,1);
        add(1,1,1,0,0,0, 1,4,0,1);
        add(0,1,1,0,0,0, 0,4,0,1);
        add(1,0,1,0,0,0, 0,3,0,0);
        // stop at 0 going down
        add(1,0,1,0,0,0, 0,2,0,0); add(1,0,1,0,0,0, 0,1,0,0);
        add(1,0,1,0,0,0, 0,0,0,0); add(1,0,1,0,0,0, 1,0,0,1);
        add(1,0,1,0,0,0, 1,0,0,1);
        // switching to wrap mode takes effect at once and clears DONE
        add(1,0,0,0,0,0, 1,4,1,0);
        add(1,1,1,0,0,0, 1,4,0,1);
        // clear drops DONE
        add(0,1,1,1,0,0, 0,0,0,0);
`ifdef MODCNT_LOAD_EN
        add(1,1,0,0,1,2, 0,2,0,0);
        add(0,1,0,0,1,7, 0,4,0,0);
        add(1,1,1,0,0,0, 1,4,0,1);
        add(0,1,0,0,1,4, 0,4,0,0);
        add(0,1,0,0,1,5, 0,4,0,0);
        add(0,1,0,0,1,0, 0,0,0,0);
        add(1,1,0,0,1,3, 0,3,0,0);
        add(1,1,0,1,1,3, 0,0,0,0);
`endif

        RESET = 1'b1; EN = 1'b0; UP = 1'b1; MODE = 1'b0; CLR = 1'b0; LOAD = 1'b0; D = '0;
        rst16 = 1'b1; en16 = 1'b0; up16 = 1'b1; mode16 = 1'b0; clr16 = 1'b0; load16 = 1'b0; d16 = '0;

        #1;
        chk("reset q", Q, 0);
        chk("reset wrap", WRAP, 0);
        chk("reset done", DONE, 0);
        chk("reset tc", TC, 0);
        @(negedge CLK);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            @(negedge CLK);
            EN = vecs[i].en; UP = vecs[i].up; MODE = vecs[i].mode;
            CLR = vecs[i].clr; LOAD = vecs[i].load; D = vecs[i].d;
            #1;
            chk($sformatf("row%0d tc", i), TC, vecs[i].tc);
            r.q = vecs[i].q; r.wrap = vecs[i].wrap; r.done = vecs[i].done;
            sb.push_back(r);
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("row%0d scoreboard empty", i), 1, 0);
            end else begin
                r = sb.pop_front();
                chk($sformatf("row%0d q", i), Q, r.q);
                chk($sformatf("row%0d wrap", i), WRAP, r.wrap);
                chk($sformatf("row%0d done", i), DONE, r.done);
            end
        end
        chk("scoreboard drained", sb.size(), 0);

        // asynchronous reset mid-count
        @(negedge CLK);
        EN = 1'b1; UP = 1'b1; MODE = 1'b0; CLR = 1'b0; LOAD = 1'b0;
        @(posedge CLK); #1;
        chk("pre-reset q1", Q, 1);
        @(posedge CLK); #1;
        chk("pre-reset q2", Q, 2);
        #2 RESET = 1'b1;
        #1;
        chk("async reset q", Q, 0);
        chk("async reset wrap", WRAP, 0);
        chk("async reset done", DONE, 0);
        @(posedge CLK); #1;
        chk("reset held over edge q", Q, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("resume first edge q", Q, 1);
`ifdef MODCNT_LOAD_EN
        // reset discards a pending load
        @(negedge CLK);
        EN = 1'b0; LOAD = 1'b1; D = 3'd3;
        #1 RESET = 1'b1;
        @(posedge CLK); #1;
        chk("reset discards load q", Q, 0);
        @(negedge CLK);
        RESET = 1'b0; LOAD = 1'b0;
`endif

        // WIDTH=4, MODULUS=16 full-range wrap
        @(negedge CLK);
        rst16 = 1'b0; en16 = 1'b1; up16 = 1'b1; mode16 = 1'b0;
        for (int unsigned i = 1; i <= 15; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("w16 up q%0d", i), q16, i);
        end
        chk("w16 tc at 15", tc16, 1);
        @(posedge CLK); #1;
        chk("w16 wrap q", q16, 0);
        chk("w16 wrap pulse", wrap16, 1);
        @(negedge CLK);
        up16 = 1'b0;
        #1;
        chk("w16 down tc at 0", tc16, 1);
        @(posedge CLK); #1;
        chk("w16 down wrap q", q16, 15);
        chk("w16 down wrap pulse", wrap16, 1);
        @(posedge CLK); #1;
        chk("w16 q14", q16, 14);
        chk("w16 wrap cleared", wrap16, 0);
        #2 rst16 = 1'b1;
        #1;
        chk("w16 async reset q", q16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits.
REQ-002 Parameter MODULUS, default 5: count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 EN  input  1  count enable.
REQ-006 UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 MODE  input  1  boundary behaviour: 0 = wrap, 1 = stop at boundary.
REQ-008 CLR  input  1  synchronous clear to 0.
REQ-009 LOAD  input  1  synchronous parallel load; present only when MODCNT_LOAD_EN is defined.
REQ-010 D  input  WIDTH  load value; present only when MODCNT_LOAD_EN is defined.
REQ-011 Q  output  WIDTH  registered count value.
REQ-012 TC  output  1  combinational terminal count: EN high and Q at the boundary for the current UP.
REQ-013 WRAP  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.
REQ-014 DONE  output  1  registered sticky flag: the stop-mode boundary has been reached.

Function
REQ-015 Boundary: Q == MODULUS-1 when UP = 1; Q == 0 when UP = 0.
REQ-016 Per-edge priority: CLR, then LOAD (if compiled in), then EN count, else hold.
REQ-017 CLR: Q <= 0, WRAP <= 0, DONE <= 0, regardless of EN, LOAD or MODE.
REQ-018 LOAD: Q <= D if D < MODULUS, else Q <= MODULUS-1 (clamp); WRAP <= 0; DONE <= 0.
REQ-019 EN, not at boundary: Q <= Q+1 (UP = 1) or Q-1 (UP = 0); WRAP <= 0; DONE <= 0.
REQ-020 EN, at boundary, MODE = 0: Q <= 0 (UP = 1) or MODULUS-1 (UP = 0); WRAP <= 1 for exactly one cycle.
REQ-021 EN, at boundary, MODE = 1: Q holds; DONE <= 1; WRAP <= 0.
REQ-022 DONE stays high while Q holds.
REQ-023 DONE clears on the first edge at which Q changes by count, CLR, LOAD or RESET.
REQ-024 EN low with no CLR or LOAD: Q and DONE hold; WRAP <= 0.
REQ-025 Q never leaves the range 0..MODULUS-1 under any input sequence.
REQ-026 MODE and UP may change on any cycle; they take effect at the next edge, with no pipeline delay.
REQ-027 TC = EN & (Q at the boundary for the current UP); TC has zero latency and is independent of MODE.
REQ-028 All arithmetic is WIDTH bits wide; MODULUS = 2**WIDTH shall wrap correctly, with no overflow of intermediate values.

Reset
REQ-029 While RESET is high: Q = 0, WRAP = 0, DONE = 0, asynchronously and regardless of CLK.
REQ-030 Counting resumes on the first rising CLK edge after RESET deasserts.
REQ-031 RESET asserted mid-count or mid-load discards that operation.

Configuration
REQ-032 With MODCNT_LOAD_EN defined: LOAD and D ports exist and REQ-018 applies.
REQ-033 With MODCNT_LOAD_EN undefined: LOAD and D ports are absent and no load logic exists; all other behaviour is identical.

Verification
REQ-034 Defaults, RESET pulse, then EN = 1, UP = 1, MODE = 0 for 12 cycles -> Q sequence 0,1,2,3,4,0,1,2,3,4,0,1,2; WRAP high in the cycle after each 4->0; TC high whenever Q = 4.
REQ-035 UP = 0, MODE = 0 from Q = 0 -> Q = 4 next cycle with a WRAP pulse; then 3,2,1,0.
REQ-036 MODE = 1, UP = 1 from Q = 3 -> Q = 4; next cycle Q = 4, DONE = 1, held over 5 more cycles; then UP = 0 -> Q = 3, DONE = 0.
REQ-037 MODCNT_LOAD_EN defined: LOAD with D = 2 -> Q = 2; LOAD with D = 7 -> Q = 4; CLR, LOAD and EN together -> Q = 0.
REQ-038 WIDTH = 4, MODULUS = 16, UP = 1 from Q = 15 -> Q = 0 with a WRAP pulse; RESET asserted between edges -> Q = 0 immediately, before the next CLK edge.
